mod12_cnt_sched: RTL and testbench

Two-requester command scheduler for the mod-12 up/down counter. It arbitrates between two clients, each issuing LOAD, count-UP-N or count-DOWN-N commands. It drives the counter's `load`, `mode` and `data_in` pins and holds the count between commands. It sits directly in front of one counter instance and is the only agent that drives its control pins.

---
 rtl/mod12_cnt_sched.sv | 214 +++++++++++++++++++++
 tb/tb_mod12_cnt_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod12_cnt_sched.sv
// mod12_cnt_sched: two-requester round-robin command scheduler that drives the
// load/mode/data_in pins of a mod-MOD up/down counter. Commands are LOAD,
// UP-by-N and DOWN-by-N. Between commands the counter is held by reloading
// its own value.
module mod12_cnt_sched #(
  parameter int MOD = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [3:0] arg0,
  input  logic [3:0] arg1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       err,
  output logic       busy,
  output logic       cnt_load,
  output logic       cnt_mode,
  output logic [3:0] cnt_data_in,
  input  logic [3:0] cnt_data_out
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_BAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Per-requester command view and classification.
  logic [1:0] op_vec   [2];
  logic [3:0] arg_vec  [2];
  logic [1:0] load_ok;
  logic [1:0] step_cmd;
  logic [1:0] reject;

  assign op_vec[0]  = op0;
  assign op_vec[1]  = op1;
  assign arg_vec[0] = arg0;
  assign arg_vec[1] = arg1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cls
      // A LOAD is only legal when its value is a valid counter value.
      assign load_ok[gi]  = (op_vec[gi] == OP_LOAD) && (int'(arg_vec[gi]) < MOD);
      // A zero-length step is not an error, it just completes without moving.
      assign step_cmd[gi] = ((op_vec[gi] == OP_UP) || (op_vec[gi] == OP_DOWN)) &&
                            (arg_vec[gi] != 4'd0);
      assign reject[gi]   = (op_vec[gi] == OP_BAD) ||
                            ((op_vec[gi] == OP_LOAD) && !load_ok[gi]);
    end
  endgenerate

  // Latched command context.
  logic       ptr_reg, ptr_next;             // last granted requester
  logic       served_reg, served_next;       // requester being served
  logic       step_up_reg, step_up_next;     // direction of a STEP command
  logic [3:0] arg_reg, arg_next;             // LOAD value
  logic [3:0] remaining_reg, remaining_next; // steps left including current
  logic       hold_only_reg, hold_only_next; // rejected/zero-step: no counter move
  logic       err_flag_reg, err_flag_next;   // completion status to report

  // Registered outputs and the data_in mux select.
  logic [1:0] gnt_next, done_next;
  logic       err_next, busy_next, cnt_load_next, cnt_mode_next;
  logic       drive_arg_reg, drive_arg_next;

  // Arbitration: single requester always wins, on contention the one not served last.
  logic win;
  logic accept;

  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~ptr_reg;
    end else if (req[1]) begin
      win = 1'b1;
    end
  end

  // New commands are taken in IDLE and at the end of DONE, so no bubble follows DONE.
  assign accept = ((state_reg == S_IDLE) || (state_reg == S_DONE)) && (req != 2'b00);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. Rejected and zero-step commands pass through the LOAD
  // state with the hold drive so their done lands one cycle after grant.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (step_cmd[win]) begin
            state_next = S_STEP;
          end else begin
            state_next = S_LOAD;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LOAD: state_next = S_DONE;
      S_STEP: begin
        if (remaining_reg == 4'd1) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command context: latch the winner's command on accept, count steps down in STEP.
  always_comb begin
    ptr_next       = ptr_reg;
    served_next    = served_reg;
    step_up_next   = step_up_reg;
    arg_next       = arg_reg;
    remaining_next = remaining_reg;
    hold_only_next = hold_only_reg;
    err_flag_next  = err_flag_reg;
    if (accept) begin
      ptr_next       = win;
      served_next    = win;
      step_up_next   = (op_vec[win] == OP_UP);
      arg_next       = arg_vec[win];
      remaining_next = arg_vec[win];
      hold_only_next = !load_ok[win] && !step_cmd[win];
      err_flag_next  = reject[win];
    end else if (state_reg == S_STEP) begin
      remaining_next = remaining_reg - 4'd1;
    end
  end

  // Command context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= 1'b1;
      served_reg    <= 1'b0;
      step_up_reg   <= 1'b0;
      arg_reg       <= 4'd0;
      remaining_reg <= 4'd0;
      hold_only_reg <= 1'b0;
      err_flag_reg  <= 1'b0;
    end else begin
      ptr_reg       <= ptr_next;
      served_reg    <= served_next;
      step_up_reg   <= step_up_next;
      arg_reg       <= arg_next;
      remaining_reg <= remaining_next;
      hold_only_reg <= hold_only_next;
      err_flag_reg  <= err_flag_next;
    end
  end

  // Output logic: next values of the registered outputs, derived from the next state.
  always_comb begin
    gnt_next       = 2'b00;
    done_next      = 2'b00;
    err_next       = 1'b0;
    busy_next      = (state_next != S_IDLE);
    cnt_load_next  = (state_next != S_STEP);
    cnt_mode_next  = (state_next == S_STEP) && step_up_next;
    drive_arg_next = (state_next == S_LOAD) && !hold_only_next;
    if (accept) begin
      gnt_next = win ? 2'b10 : 2'b01;
    end
    if (state_next == S_DONE) begin
      done_next = served_reg ? 2'b10 : 2'b01;
      err_next  = err_flag_reg;
    end
  end

  // Output registers; reset drops any command in flight without a done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt           <= 2'b00;
      done          <= 2'b00;
      err           <= 1'b0;
      busy          <= 1'b0;
      cnt_load      <= 1'b1;
      cnt_mode      <= 1'b0;
      drive_arg_reg <= 1'b0;
    end else begin
      gnt           <= gnt_next;
      done          <= done_next;
      err           <= err_next;
      busy          <= busy_next;
      cnt_load      <= cnt_load_next;
      cnt_mode      <= cnt_mode_next;
      drive_arg_reg <= drive_arg_next;
    end
  end

  // Counter data: the LOAD value during a real LOAD, otherwise the counter's own value.
  assign cnt_data_in = drive_arg_reg ? arg_reg : cnt_data_out;

endmodule

// File: tb/tb_mod12_cnt_sched.sv
// tb_mod12_cnt_sched: directed commands against mod12_cnt_sched driving a
// behavioural mod-12 counter. Expected grants and completions are queued by
// the stimulus and checked by an independent monitor.
module tb_mod12_cnt_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] op0 = 2'b00;
  logic [1:0] op1 = 2'b00;
  logic [3:0] arg0 = 4'd0;
  logic [3:0] arg1 = 4'd0;
  logic [1:0] gnt, done;
  logic       err, busy, cnt_load, cnt_mode;
  logic [3:0] cnt_data_in;
  logic [3:0] cnt_data_out;

  mod12_cnt_sched #(.MOD(12)) dut (
    .clk(clk), .rst(rst), .req(req), .op0(op0), .op1(op1),
    .arg0(arg0), .arg1(arg1), .gnt(gnt), .done(done), .err(err),
    .busy(busy), .cnt_load(cnt_load), .cnt_mode(cnt_mode),
    .cnt_data_in(cnt_data_in), .cnt_data_out(cnt_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural mod-12 up/down counter with load.
  always @(posedge clk or posedge rst) begin
    if (rst) cnt_data_out <= 4'd0;
    else if (cnt_load) cnt_data_out <= cnt_data_in;
    else if (cnt_mode) cnt_data_out <= (cnt_data_out == 4'd11) ? 4'd0 : cnt_data_out + 4'd1;
    else cnt_data_out <= (cnt_data_out == 4'd0) ? 4'd11 : cnt_data_out - 4'd1;
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] done;
    logic       err;
    logic [3:0] cnt;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] gnt_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push_cmd(input logic [1:0] g, input logic e, input logic [3:0] c, input int lat);
    exp_t x;
    x.done = g; x.err = e; x.cnt = c; x.lat = lat;
    gnt_q.push_back(g);
    exp_q.push_back(x);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or a completion.
  int gnt_cycle = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] g;
    if (gnt !== 2'b00) begin
      gnt_cycle = cycle;
      if (gnt_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_gnt: got %b expected none", gnt);
      end else begin
        g = gnt_q.pop_front();
        chk("gnt", gnt, g);
      end
    end
    if (done !== 2'b00) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_done: got %b expected none", done);
      end else begin
        e = exp_q.pop_front();
        chk("done", done, e.done);
        chk("err", err, e.err);
        chk("done_counter", cnt_data_out, e.cnt);
        chk("done_latency", cycle - gnt_cycle, e.lat);
        $display("cmd done=%b err=%b counter=%0d latency=%0d", done, err, cnt_data_out, cycle - gnt_cycle);
      end
    end
  end

  // Wait for a grant to requester i and drop its request on that cycle.
  task automatic wait_gnt(input int i);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt[i] === 1'b1) begin
        req[i] = 1'b0;
        return;
      end
    end
    n_vec++; n_bad++;
    $display("FAIL gnt_timeout: got no grant expected grant to %0d", i);
    req[i] = 1'b0;
  endtask

  // Wait for any grant, dropping the request of whoever got it.
  task automatic wait_any_gnt();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (gnt !== 2'b00) begin
        req = req & ~gnt;
        return;
      end
    end
    n_vec++; n_bad++;
    $display("FAIL gnt_timeout: got no grant expected a grant");
    req = 2'b00;
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [3:0] arg);
    if (i == 0) begin op0 = op; arg0 = arg; end
    else begin op1 = op; arg1 = arg; end
    req[i] = 1'b1;
    wait_gnt(i);
  endtask

  // Returns at the falling edge after the done cycle.
  task automatic wait_done();
    for (int c = 0; c < 40; c++) begin
      if (done !== 2'b00) begin
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    n_vec++; n_bad++;
    $display("FAIL done_timeout: got no done expected done");
  endtask

  logic [3:0] up_seq[5]   = '{4'd10, 4'd11, 4'd0, 4'd1, 4'd2};
  logic [3:0] down_seq[3] = '{4'd0, 4'd11, 4'd10};

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_load", cnt_load, 1);
    chk("rst_cnt_mode", cnt_mode, 0);
    chk("rst_data_in", cnt_data_in, cnt_data_out);
    rst = 1'b0;
    @(negedge clk);

    // LOAD 7 from requester 0.
    push_cmd(2'b01, 1'b0, 4'd7, 1);
    issue(0, 2'b00, 4'd7);
    chk("load_busy", busy, 1);
    chk("load_cnt_load", cnt_load, 1);
    chk("load_data_in", cnt_data_in, 7);
    wait_done();
    chk("load_idle_busy", busy, 0);
    chk("load_counter", cnt_data_out, 7);

    // Counter to 9, then UP 5 from requester 1 with wrap.
    push_cmd(2'b10, 1'b0, 4'd9, 1);
    issue(1, 2'b00, 4'd9);
    wait_done();
    push_cmd(2'b10, 1'b0, 4'd2, 5);
    issue(1, 2'b01, 4'd5);
    for (int k = 0; k < 5; k++) begin
      chk("up_cnt_load", cnt_load, 0);
      chk("up_cnt_mode", cnt_mode, 1);
      @(negedge clk);
      chk("up_counter", cnt_data_out, up_seq[k]);
    end
    chk("up_done_cnt_load", cnt_load, 1);
    wait_done();
    chk("up_hold", cnt_data_out, 2);

    // Counter to 1, then DOWN 3 from requester 0 with wrap, then idle hold.
    push_cmd(2'b01, 1'b0, 4'd1, 1);
    issue(0, 2'b00, 4'd1);
    wait_done();
    push_cmd(2'b01, 1'b0, 4'd10, 3);
    issue(0, 2'b10, 4'd3);
    for (int k = 0; k < 3; k++) begin
      chk("down_cnt_load", cnt_load, 0);
      chk("down_cnt_mode", cnt_mode, 0);
      @(negedge clk);
      chk("down_counter", cnt_data_out, down_seq[k]);
    end
    wait_done();
    repeat (20) @(negedge clk);
    chk("down_hold", cnt_data_out, 10);
    chk("down_idle_busy", busy, 0);

    // Rejected and zero-step commands.
    push_cmd(2'b01, 1'b1, 4'd10, 1);
    issue(0, 2'b00, 4'd12);
    chk("rej_cnt_load", cnt_load, 1);
    chk("rej_data_in", cnt_data_in, cnt_data_out);
    wait_done();
    push_cmd(2'b01, 1'b1, 4'd10, 1);
    issue(0, 2'b11, 4'd5);
    wait_done();
    push_cmd(2'b10, 1'b0, 4'd10, 1);
    issue(1, 2'b01, 4'd0);
    wait_done();
    chk("rej_counter", cnt_data_out, 10);

    // Contention: LOAD 3 vs LOAD 4, two rounds; expect 0,1,0,1.
    op0 = 2'b00; arg0 = 4'd3;
    op1 = 2'b00; arg1 = 4'd4;
    for (int r = 0; r < 2; r++) begin
      push_cmd(2'b01, 1'b0, 4'd3, 1);
      push_cmd(2'b10, 1'b0, 4'd4, 1);
      req = 2'b11;
      wait_any_gnt();
      wait_any_gnt();
      wait_done();
    end
    chk("rr_counter", cnt_data_out, 4);

    // UP 10 from 0, aborted by reset after 4 steps.
    push_cmd(2'b01, 1'b0, 4'd0, 1);
    issue(0, 2'b00, 4'd0);
    wait_done();
    gnt_q.push_back(2'b10);
    issue(1, 2'b01, 4'd10);
    repeat (4) @(negedge clk);
    chk("abort_steps", cnt_data_out, 4);
    #2 rst = 1'b1;
    #1;
    chk("abort_gnt", gnt, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cnt_load", cnt_load, 1);
    chk("abort_cnt_mode", cnt_mode, 0);
    chk("abort_data_in", cnt_data_in, cnt_data_out);
    chk("abort_counter", cnt_data_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_hold", cnt_data_out, 0);
    chk("abort_idle_busy", busy, 0);

    chk("pending_done", exp_q.size(), 0);
    chk("pending_gnt", gnt_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
